seg7_capture: RTL and testbench

Snoops the multiplexed, active-low anode/segment lines driven to the 7-segment display and reconstructs the hex value shown on each digit. It is the inverse of the hex-to-segment decoder and is used for on-chip self-check and bench loopback of the display path. The block waits for each scanned pattern to be stable, decodes it back to a nibble, and flags blank or unrecognised patterns per digit.

---
 rtl/seg7_capture.sv | 164 ++++++++++++++++
 tb/tb_seg7_capture.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - reconstructs hex digits from snooped active-low 7-segment scan lines
// Waits for each scanned pattern to dwell STABLE_CYCLES+1 edges, then decodes it to a nibble per digit.
module seg7_capture #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              cnode,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   err,
  output logic                    multi_an,
  output logic                    frame_done
);

  localparam int SW = NUM_DIGITS + 7;
  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SW-1:0]           in_q, in_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    armed_q, armed_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    multi_q, multi_d;
  logic                    fd_q, fd_d;

  logic                    same;
  logic                    capture;
  logic                    hit;
  logic                    is_blank;
  logic [3:0]              nib;
  logic [3:0]              low_cnt;
  logic [NUM_DIGITS-1:0]   seen_upd;

  // Inverse of the hex-to-segment table; segments are active-low, a..g from bit 6 down.
  always_comb begin
    hit      = 1'b1;
    nib      = 4'h0;
    is_blank = 1'b0;
    case (in_q[6:0])
      7'b0000001: nib = 4'h0;
      7'b1001111: nib = 4'h1;
      7'b0010010: nib = 4'h2;
      7'b0000110: nib = 4'h3;
      7'b1001100: nib = 4'h4;
      7'b0100100: nib = 4'h5;
      7'b0100000: nib = 4'h6;
      7'b0001111: nib = 4'h7;
      7'b0000000: nib = 4'h8;
      7'b0001100: nib = 4'h9;
      7'b0001000: nib = 4'hA;
      7'b1100000: nib = 4'hB;
      7'b0110001: nib = 4'hC;
      7'b1000010: nib = 4'hD;
      7'b0110000: nib = 4'hE;
      7'b0111000: nib = 4'hF;
      7'b1111111: begin
        hit      = 1'b0;
        is_blank = 1'b1;
      end
      default:    hit = 1'b0;
    endcase
  end

  always_comb begin
    in_d     = {an, cnode};
    same     = (in_d == in_q);
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    digits_d = digits_q;
    valid_d  = valid_q;
    blank_d  = blank_q;
    err_d    = err_q;
    seen_d   = seen_q;
    multi_d  = multi_q;
    fd_d     = 1'b0;
    seen_upd = seen_q;
    low_cnt  = 4'd0;

    if (!same) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end

    capture = same && armed_q && (cnt_q == CNT_MAX);
    if (capture) armed_d = 1'b0;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!in_q[7+i]) low_cnt = low_cnt + 4'd1;
    end

    if (clr) begin
      digits_d = '0;
      valid_d  = '0;
      blank_d  = '0;
      err_d    = '0;
      seen_d   = '0;
      multi_d  = 1'b0;
    end else if (capture) begin
      if (low_cnt > 4'd1) multi_d = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (low_cnt == 4'd1 && !in_q[7+i]) begin
          seen_upd[i] = 1'b1;
          valid_d[i]  = hit;
          blank_d[i]  = is_blank;
          err_d[i]    = !hit && !is_blank;
          if (hit)      digits_d[4*i +: 4] = nib;
          if (is_blank) digits_d[4*i +: 4] = 4'h0;
        end
      end
      // Completing a frame clears the mask so the next frame starts counting immediately.
      if (&seen_upd) begin
        fd_d   = 1'b1;
        seen_d = '0;
      end else begin
        seen_d = seen_upd;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q     <= '1;
      cnt_q    <= '0;
      armed_q  <= 1'b1;
      digits_q <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      err_q    <= '0;
      seen_q   <= '0;
      multi_q  <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      in_q     <= in_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
      multi_q  <= multi_d;
      fd_q     <= fd_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign blank       = blank_q;
  assign err         = err_q;
  assign multi_an    = multi_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - self-checking bench for seg7_capture
// A run-length model predicts every output each cycle; literal checks pin key scenarios.
module tb_seg7_capture;

  localparam int ND = 8;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic [ND-1:0] an = '1;
  logic [6:0]    cnode = '1;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] digit_valid, blank, err;
  logic          multi_an, frame_done;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .an(an), .cnode(cnode),
    .digits(digits), .digit_valid(digit_valid), .blank(blank), .err(err),
    .multi_an(multi_an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int fd_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] codes [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Model: a capture happens exactly when the current run of identical samples reaches SC+1.
  logic [14:0] m_prev;
  int          m_run;
  logic [31:0] m_digits;
  logic [7:0]  m_valid, m_blank, m_err, m_seen;
  logic        m_multi, m_fd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = '1; m_run = 1;
      m_digits = 0; m_valid = 0; m_blank = 0; m_err = 0; m_seen = 0;
      m_multi = 0; m_fd = 0;
    end else begin
      logic [14:0] x;
      int nlow, idx, val;
      x = {an, cnode};
      if (x == m_prev) m_run++; else m_run = 1;
      m_prev = x;
      m_fd = 0;
      if (clr) begin
        m_digits = 0; m_valid = 0; m_blank = 0; m_err = 0; m_seen = 0; m_multi = 0;
      end else if (m_run == SC + 1) begin
        nlow = $countones(~x[14:7]);
        idx = 0;
        for (int k = 0; k < ND; k++) if (!x[7+k]) idx = k;
        if (nlow > 1) m_multi = 1;
        else if (nlow == 1) begin
          val = -1;
          for (int c = 0; c < 16; c++) if (codes[c] == x[6:0]) val = c;
          m_valid[idx] = (val >= 0);
          m_blank[idx] = (x[6:0] == 7'h7f);
          m_err[idx]   = (val < 0) && (x[6:0] != 7'h7f);
          if (val >= 0) m_digits[4*idx +: 4] = 4'(val);
          if (x[6:0] == 7'h7f) m_digits[4*idx +: 4] = 0;
          m_seen[idx] = 1;
          if (m_seen == 8'hff) begin
            m_fd = 1;
            m_seen = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("digits", digits, m_digits);
    chk("digit_valid", 32'(digit_valid), 32'(m_valid));
    chk("blank", 32'(blank), 32'(m_blank));
    chk("err", 32'(err), 32'(m_err));
    chk("multi_an", 32'(multi_an), 32'(m_multi));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    if (frame_done) fd_cnt++;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic hold(input logic [7:0] a, input logic [6:0] c, input int n);
    an = a;
    cnode = c;
    edges(n);
  endtask

  logic [31:0] snap_d;
  logic [7:0]  snap_v, snap_b, snap_e;

  initial begin
    edges(2);
    chk("reset_digits", digits, 0);
    chk("reset_valid", 32'(digit_valid), 0);
    rst_n = 1'b1;

    // Single capture after 5 edges, none afterwards.
    hold(8'b11111110, codes[2], 4);
    chk("lat_before", 32'(digit_valid), 0);
    edges(1);
    chk("lat_digit0", 32'(digits[3:0]), 32'h2);
    chk("lat_valid0", 32'(digit_valid[0]), 1);
    edges(1);

    // Full scan of 1..8.
    clr = 1'b1; edges(1); clr = 1'b0;
    fd_cnt = 0;
    for (int d = 0; d < ND; d++) hold(~(8'd1 << d), codes[d+1], 8);
    chk("scan_digits", digits, 32'h87654321);
    chk("scan_valid", 32'(digit_valid), 32'hff);
    chk("scan_fd_count", fd_cnt, 1);

    // Blank, error, hit, error on digit 3.
    hold(8'b11110111, 7'b1111111, 8);
    chk("blank3", 32'(blank[3]), 1);
    chk("blank_valid3", 32'(digit_valid[3]), 0);
    chk("blank_nib3", 32'(digits[15:12]), 0);
    hold(8'b11110111, 7'b1010101, 8);
    chk("err3", 32'(err[3]), 1);
    chk("err_nib3", 32'(digits[15:12]), 0);
    hold(8'b11110111, codes[9], 8);
    hold(8'b11110111, 7'b1010101, 8);
    chk("err3_keep", 32'(digits[15:12]), 32'h9);
    chk("err3_valid", 32'(digit_valid[3]), 0);

    // Bouncing pattern never captures.
    snap_d = digits; snap_v = digit_valid; snap_b = blank; snap_e = err;
    fd_cnt = 0;
    for (int t = 0; t < 10; t++) hold(8'b11111101, codes[2 + (t % 2)], 2);
    chk("bounce_digits", digits, snap_d);
    chk("bounce_valid", 32'(digit_valid), 32'(snap_v));
    chk("bounce_blank", 32'(blank), 32'(snap_b));
    chk("bounce_err", 32'(err), 32'(snap_e));
    chk("bounce_fd", fd_cnt, 0);

    // Two anodes low, then clear.
    hold(8'b11111100, codes[5], 6);
    chk("multi_set", 32'(multi_an), 1);
    chk("multi_digits", digits, snap_d);
    clr = 1'b1; edges(1); clr = 1'b0;
    edges(1);
    chk("clr_digits", digits, 0);
    chk("clr_valid", 32'(digit_valid), 0);
    chk("clr_err", 32'(err), 0);
    chk("clr_multi", 32'(multi_an), 0);

    // Reset mid-dwell restarts the dwell.
    hold(8'b11011111, codes[10], 2);
    rst_n = 1'b0;
    edges(1);
    rst_n = 1'b1;
    edges(4);
    chk("rst_before", 32'(digit_valid[5]), 0);
    edges(1);
    chk("rst_nib5", 32'(digits[23:20]), 32'hA);
    chk("rst_valid5", 32'(digit_valid[5]), 1);
    edges(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
